vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with pixel-request/return pipeline, replacing the fixed 640x480 controller logic.
- Derives a pixel-enable tick from CLK50MHZ and runs horizontal/vertical counters from it.
- Issues pixel coordinates to the game-board renderer (casilla/jugador drawing logic) and accepts its colour PIX_LAT ticks later.
- Aligns sync and blank to the returned colour and drives the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, CLK50MHZ cycles per pixel tick; must be even and >= 2
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS
PIX_LAT, 2, renderer latency in ticks; range 0..8
COLOR_W, 8, bits per colour channel

Ports:
CLK50MHZ  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  timing runs while high; freezes all state while low
pix_r  in  COLOR_W  renderer red, valid PIX_LAT ticks after pix_req
pix_g  in  COLOR_W  renderer green
pix_b  in  COLOR_W  renderer blue
pix_x  out  HW=$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  current column
pix_y  out  VW=$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  current line
pix_req  out  1  high while (pix_x,pix_y) is in the active area
frame_start  out  1  one-CLK50MHZ-cycle pulse at the tick where h=0 and v=0
VGA_R  out  COLOR_W  red to DAC
VGA_G  out  COLOR_W  green to DAC
VGA_B  out  COLOR_W  blue to DAC
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_BLANK_N  out  1  low outside the active area
VGA_CLK  out  1  pixel clock to DAC (the CLK25MHZ equivalent at CLK_DIV=2)

Behaviour:
- Everything is clocked by CLK50MHZ; no derived clock drives logic.
- div_cnt counts 0..CLK_DIV-1 while enable is high; tick = (div_cnt==CLK_DIV-1).
- VGA_CLK = (div_cnt < CLK_DIV/2) ? 0 : 1, registered. It rises mid-period; data changes only on the tick edge.
- On tick, h advances. When h reaches H_TOTAL-1 it wraps to 0 and v advances. When v reaches V_TOTAL-1 it wraps to 0. Counters are unsigned with no other wrap.
- Stage-0 signals are registered on tick from the new h/v: pix_x=h, pix_y=v, pix_req=(h<H_ACTIVE && v<V_ACTIVE).
- hs0 is asserted when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs0 is asserted when v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- hs0, vs0 and pix_req pass through a PIX_LAT-deep tick-enabled delay line. At its output:
  - VGA_HS = hsd ? HS_POL : ~HS_POL; VGA_VS likewise with VS_POL.
  - VGA_BLANK_N = actd.
  - VGA_R/G/B = actd ? pix_r/g/b : 0, sampled on tick.
- PIX_LAT=0 means no delay: colour is sampled on the same tick as the stage-0 update, so the renderer must be combinational.
- frame_start is high for exactly the one CLK50MHZ cycle following the tick that loads h=0, v=0.
- enable low: div_cnt, counters and delay line hold; outputs hold; frame_start=0. Resuming continues from the held position with no extra tick.
- Reset (at any time, including mid-line or mid-frame) returns every output to its reset value on the next edge:
  - div_cnt=0, h=0, v=0, delay line cleared to inactive
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0, VGA_R/G/B=0
  - pix_x=0, pix_y=0, pix_req=0, frame_start=0, VGA_CLK=0
- First tick after reset loads h=0, v=0 and therefore pulses frame_start.
- reset and enable high together: reset wins.

Decomposition:
- vga_pkg holds:
  - typedef vga_timing_t (active, fp, sync, bp, each 12-bit)
  - constants VGA_640x480 and VGA_800x600 for the parameter defaults
  - function total() returning active+fp+sync+bp
- One sub-module, vga_delay_line: parametrised width and depth, tick-enabled shift register, depth 0 = pass-through. Instantiated once for {hs0, vs0, pix_req}.

Test Plan:
- Defaults; reset held 4 cycles then enable=1 -> VGA_HS/VS=1, BLANK_N=0, RGB=0 during reset; frame_start pulses once, 2 clocks after enable.
- Defaults -> VGA_HS low for 192 clocks per line, falling edge 1312 clocks after line start (h=656, accounting for PIX_LAT). Line period 1600 clocks; VGA_VS low for 3200 clocks; frame period 840000 clocks.
- PIX_LAT=2, renderer returns pix_r = pix_x[7:0] two ticks after request -> VGA_R steps 0,1,2,... aligned with BLANK_N rising; VGA_R=0 whenever BLANK_N=0.
- Tiny timing (H 4/1/1/1, V 3/1/1/1, CLK_DIV=4) -> h wraps 6->0, v wraps 5->0; frame_start period = 7*6*4 = 168 clocks; VGA_CLK period 4 clocks.
- Reset asserted at h=300, v=200 -> next edge all outputs at reset values; after release the frame restarts at 0,0 with a frame_start pulse.
- enable low for 50 clocks mid-line -> pix_x, VGA_* frozen; HS low width still exactly 192 enabled clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and the line/frame total helper.
package vga_pkg;

    typedef struct packed {
        logic [11:0] active;
        logic [11:0] fp;
        logic [11:0] sync;
        logic [11:0] bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h: '{active: 12'd640, fp: 12'd16, sync: 12'd96,  bp: 12'd48},
        v: '{active: 12'd480, fp: 12'd10, sync: 12'd2,   bp: 12'd33}
    };

    localparam vga_mode_t VGA_800x600 = '{
        h: '{active: 12'd800, fp: 12'd40, sync: 12'd128, bp: 12'd88},
        v: '{active: 12'd600, fp: 12'd1,  sync: 12'd4,   bp: 12'd23}
    };

    function automatic int unsigned total(vga_timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register; DEPTH of zero passes the input straight through.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = ^{i_clk, i_rst, i_en};
        assign o_q      = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_pipe [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
            end else if (i_en) begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_q = r_pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel tick divider, h/v counters, renderer request
// and a latency-matched sync/blank/colour output stage, all on CLK50MHZ.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 32'(VGA_640x480.h.active),
    parameter int unsigned H_FP     = 32'(VGA_640x480.h.fp),
    parameter int unsigned H_SYNC   = 32'(VGA_640x480.h.sync),
    parameter int unsigned H_BP     = 32'(VGA_640x480.h.bp),
    parameter int unsigned V_ACTIVE = 32'(VGA_640x480.v.active),
    parameter int unsigned V_FP     = 32'(VGA_640x480.v.fp),
    parameter int unsigned V_SYNC   = 32'(VGA_640x480.v.sync),
    parameter int unsigned V_BP     = 32'(VGA_640x480.v.bp),
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_LAT  = 2,
    parameter int unsigned COLOR_W  = 8,
    localparam vga_timing_t H_CFG   = '{active: 12'(H_ACTIVE), fp: 12'(H_FP),
                                        sync: 12'(H_SYNC), bp: 12'(H_BP)},
    localparam vga_timing_t V_CFG   = '{active: 12'(V_ACTIVE), fp: 12'(V_FP),
                                        sync: 12'(V_SYNC), bp: 12'(V_BP)},
    localparam int unsigned H_TOTAL = total(H_CFG),
    localparam int unsigned V_TOTAL = total(V_CFG),
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic               CLK50MHZ,
    input  logic               reset,
    input  logic               enable,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [HW-1:0]      pix_x,
    output logic [VW-1:0]      pix_y,
    output logic               pix_req,
    output logic               frame_start,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_CLK
);

    localparam int unsigned DW = $clog2(CLK_DIV);

    logic [DW-1:0]      r_div;
    logic               r_vclk;
    logic               r_run;
    logic [HW-1:0]      r_h;
    logic [VW-1:0]      r_v;
    logic               r_req, r_hs0, r_vs0;
    logic               r_frame;
    logic               r_vga_hs, r_vga_vs, r_vga_bn;
    logic [COLOR_W-1:0] r_vga_r, r_vga_g, r_vga_b;

    logic               w_tick;
    logic [DW-1:0]      w_div_nx;
    logic [HW-1:0]      w_h_nx;
    logic [VW-1:0]      w_v_nx;
    logic               w_req_nx, w_hs_nx, w_vs_nx;
    logic [2:0]         w_dly;
    logic               w_hsd, w_vsd, w_actd;

    assign w_tick   = enable && (r_div == DW'(CLK_DIV - 1));
    assign w_div_nx = w_tick ? '0 : r_div + 1'b1;

    // The first tick after reset presents (0,0) instead of advancing past it.
    always_comb begin
        w_h_nx = r_h;
        w_v_nx = r_v;
        if (r_run) begin
            if (r_h == HW'(H_TOTAL - 1)) begin
                w_h_nx = '0;
                w_v_nx = (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
            end else begin
                w_h_nx = r_h + 1'b1;
            end
        end
    end

    assign w_req_nx = (32'(w_h_nx) < H_ACTIVE) && (32'(w_v_nx) < V_ACTIVE);
    assign w_hs_nx  = (32'(w_h_nx) >= H_ACTIVE + H_FP) &&
                      (32'(w_h_nx) <  H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_nx  = (32'(w_v_nx) >= V_ACTIVE + V_FP) &&
                      (32'(w_v_nx) <  V_ACTIVE + V_FP + V_SYNC);

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIX_LAT)
    ) u_dly (
        .i_clk (CLK50MHZ),
        .i_rst (reset),
        .i_en  (w_tick),
        .i_d   ({r_hs0, r_vs0, r_req}),
        .o_q   (w_dly)
    );

    assign {w_hsd, w_vsd, w_actd} = w_dly;

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            r_div    <= '0;
            r_vclk   <= 1'b0;
            r_run    <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
            r_req    <= 1'b0;
            r_hs0    <= 1'b0;
            r_vs0    <= 1'b0;
            r_frame  <= 1'b0;
            r_vga_hs <= ~HS_POL;
            r_vga_vs <= ~VS_POL;
            r_vga_bn <= 1'b0;
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
        end else begin
            r_frame <= 1'b0;
            if (enable) begin
                r_div  <= w_div_nx;
                r_vclk <= (w_div_nx >= DW'(CLK_DIV / 2));
            end
            if (w_tick) begin
                r_run    <= 1'b1;
                r_h      <= w_h_nx;
                r_v      <= w_v_nx;
                r_req    <= w_req_nx;
                r_hs0    <= w_hs_nx;
                r_vs0    <= w_vs_nx;
                r_frame  <= (w_h_nx == '0) && (w_v_nx == '0);
                r_vga_hs <= w_hsd ? HS_POL : ~HS_POL;
                r_vga_vs <= w_vsd ? VS_POL : ~VS_POL;
                r_vga_bn <= w_actd;
                r_vga_r  <= w_actd ? pix_r : '0;
                r_vga_g  <= w_actd ? pix_g : '0;
                r_vga_b  <= w_actd ? pix_b : '0;
            end
        end
    end

    assign pix_x       = r_h;
    assign pix_y       = r_v;
    assign pix_req     = r_req;
    assign frame_start = r_frame;
    assign VGA_HS      = r_vga_hs;
    assign VGA_VS      = r_vga_vs;
    assign VGA_BLANK_N = r_vga_bn;
    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_CLK     = r_vclk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised reset/enable stimulus on a default 640x480 instance and a tiny-timing
// instance, each compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div, lat;
        bit          hpol, vpol;
    } cfg_t;

    typedef struct {
        logic [31:0] x, y, req, fs, hs, vs, bn, r, g, b, vclk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;
    logic [7:0] sg, sb;

    // Default instance
    logic [7:0] a_r, a_g, a_b, a_vr, a_vg, a_vb;
    logic [9:0] a_x, a_y;
    logic       a_req, a_fs, a_hs, a_vs, a_bn, a_vclk;

    vga_timing_gen u_dut_a (
        .CLK50MHZ    (clk),
        .reset       (rst),
        .enable      (en),
        .pix_r       (a_r),
        .pix_g       (a_g),
        .pix_b       (a_b),
        .pix_x       (a_x),
        .pix_y       (a_y),
        .pix_req     (a_req),
        .frame_start (a_fs),
        .VGA_R       (a_vr),
        .VGA_G       (a_vg),
        .VGA_B       (a_vb),
        .VGA_HS      (a_hs),
        .VGA_VS      (a_vs),
        .VGA_BLANK_N (a_bn),
        .VGA_CLK     (a_vclk)
    );

    // Tiny instance: 7x6 raster, CLK_DIV=4, no renderer latency, active-high syncs
    logic [7:0] b_r, b_g, b_b, b_vr, b_vg, b_vb;
    logic [2:0] b_x, b_y;
    logic       b_req, b_fs, b_hs, b_vs, b_bn, b_vclk;

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (4), .HS_POL (1'b1), .VS_POL (1'b1), .PIX_LAT (0), .COLOR_W (8)
    ) u_dut_b (
        .CLK50MHZ    (clk),
        .reset       (rst),
        .enable      (en),
        .pix_r       (b_r),
        .pix_g       (b_g),
        .pix_b       (b_b),
        .pix_x       (b_x),
        .pix_y       (b_y),
        .pix_req     (b_req),
        .frame_start (b_fs),
        .VGA_R       (b_vr),
        .VGA_G       (b_vg),
        .VGA_B       (b_vb),
        .VGA_HS      (b_hs),
        .VGA_VS      (b_vs),
        .VGA_BLANK_N (b_bn),
        .VGA_CLK     (b_vclk)
    );

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0, 1'b0};
    cfg_t cfg_b = '{4, 1, 1, 1, 3, 1, 1, 1, 4, 0, 1'b1, 1'b1};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic logic [23:0] colour(int unsigned x, int unsigned y);
        int unsigned s;
        s = x + y;
        return {x[7:0], y[7:0] ^ sg, s[7:0] ^ sb};
    endfunction

    // Model state: enabled edges since reset, and whether the last edge advanced.
    int unsigned e   = 0;
    bit          adv = 1'b0;
    int unsigned rqx [2];
    int unsigned rqy [2];

    always @(posedge clk) begin
        if (rst) begin
            e   <= 0;
            adv <= 1'b0;
        end else if (en) begin
            e   <= e + 1;
            adv <= 1'b1;
        end else begin
            adv <= 1'b0;
        end
        // Two-tick renderer for the default instance
        if (!rst && en && (e % cfg_a.div == cfg_a.div - 1)) begin
            rqx[0] <= 32'(a_x);
            rqy[0] <= 32'(a_y);
            rqx[1] <= rqx[0];
            rqy[1] <= rqy[0];
        end
    end

    assign {a_r, a_g, a_b} = colour(rqx[1], rqy[1]);
    assign {b_r, b_g, b_b} = colour(32'(b_x), 32'(b_y));

    function automatic exp_t model(cfg_t c, int unsigned ev, bit av);
        exp_t        m;
        int unsigned ht, vt, k, p, q, oh, ov;
        bit          act, hsa, vsa;
        logic [23:0] col;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        k  = ev / c.div;
        m.vclk = 32'((ev % c.div) >= c.div / 2);
        if (k == 0) begin
            m.x = 0; m.y = 0; m.req = 0;
        end else begin
            p     = k - 1;
            m.x   = p % ht;
            m.y   = (p / ht) % vt;
            m.req = 32'((m.x < c.ha) && (m.y < c.va));
        end
        m.fs = 32'(av && (ev % c.div == 0) && (k >= 1) && (((k - 1) % (ht * vt)) == 0));
        if (k >= c.lat + 2) begin
            q   = k - c.lat - 2;
            oh  = q % ht;
            ov  = (q / ht) % vt;
            act = (oh < c.ha) && (ov < c.va);
            hsa = (oh >= c.ha + c.hfp) && (oh < c.ha + c.hfp + c.hsw);
            vsa = (ov >= c.va + c.vfp) && (ov < c.va + c.vfp + c.vsw);
            col = colour(oh, ov);
            m.hs = 32'(hsa ? c.hpol : !c.hpol);
            m.vs = 32'(vsa ? c.vpol : !c.vpol);
            m.bn = 32'(act);
            m.r  = act ? 32'(col[23:16]) : 0;
            m.g  = act ? 32'(col[15:8])  : 0;
            m.b  = act ? 32'(col[7:0])   : 0;
        end else begin
            m.hs = 32'(!c.hpol);
            m.vs = 32'(!c.vpol);
            m.bn = 0; m.r = 0; m.g = 0; m.b = 0;
        end
        return m;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at e=%0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic cmp_inst(input string pfx, input cfg_t c,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] req,
                            input logic [31:0] fs, input logic [31:0] hs, input logic [31:0] vs,
                            input logic [31:0] bn, input logic [31:0] r, input logic [31:0] g,
                            input logic [31:0] b, input logic [31:0] vclk);
        exp_t m;
        m = model(c, e, adv);
        check_val({pfx, "pix_x"},       x,    m.x);
        check_val({pfx, "pix_y"},       y,    m.y);
        check_val({pfx, "pix_req"},     req,  m.req);
        check_val({pfx, "frame_start"}, fs,   m.fs);
        check_val({pfx, "VGA_HS"},      hs,   m.hs);
        check_val({pfx, "VGA_VS"},      vs,   m.vs);
        check_val({pfx, "VGA_BLANK_N"}, bn,   m.bn);
        check_val({pfx, "VGA_R"},       r,    m.r);
        check_val({pfx, "VGA_G"},       g,    m.g);
        check_val({pfx, "VGA_B"},       b,    m.b);
        check_val({pfx, "VGA_CLK"},     vclk, m.vclk);
    endtask

    initial begin
        int low_left;
        low_left = 0;
        sg  = 8'($urandom());
        sb  = 8'($urandom());
        rst = 1'b1;
        en  = 1'b0;
        for (int cyc = 0; cyc < 60000 && n_err < 100; cyc++) begin
            @(negedge clk);
            cmp_inst("a.", cfg_a, 32'(a_x), 32'(a_y), 32'(a_req), 32'(a_fs), 32'(a_hs),
                     32'(a_vs), 32'(a_bn), 32'(a_vr), 32'(a_vg), 32'(a_vb), 32'(a_vclk));
            cmp_inst("b.", cfg_b, 32'(b_x), 32'(b_y), 32'(b_req), 32'(b_fs), 32'(b_hs),
                     32'(b_vs), 32'(b_bn), 32'(b_vr), 32'(b_vg), 32'(b_vb), 32'(b_vclk));
            if (cyc == 3000 || cyc == 20000) low_left = 50;
            if (cyc < 3) begin
                rst = 1'b1; en = 1'b0;
            end else if (cyc == 30000) begin
                rst = 1'b1; en = 1'b1;
            end else if (low_left > 0) begin
                rst = 1'b0; en = 1'b0;
                low_left--;
            end else if (cyc < 2000) begin
                rst = 1'b0; en = 1'b1;
            end else begin
                rst = ($urandom_range(0, 3999) == 0);
                en  = ($urandom_range(0, 9) != 0);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
